// File: rtl/image_readback_buffer.sv
// image_readback_buffer: streams a flash-stored image to the downlink framed as header | payload | checksum,
// with a credit-limited payload FIFO between the flash reader and the downlink.
module image_readback_buffer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 24
) (
    input  logic              sysClk,
    input  logic              sysRst_n,
    input  logic              readback_start,
    input  logic [15:0]       readback_image_index,
    input  logic [31:0]       readback_image_size,
    input  logic [ADDR_W-1:0] readback_start_addr,
    output logic [ADDR_W-1:0] flashmem_read_addr,
    output logic              flashmem_read_req,
    input  logic              flashmem_read_ready,
    input  logic [7:0]        byte_from_flashmem_spi,
    input  logic              byte_from_flashmem_spi_valid,
    output logic [7:0]        byte_for_downlink,
    output logic              byte_for_downlink_valid,
    input  logic              downlink_ready,
    output logic              readback_busy,
    output logic              readback_done,
    output logic              readback_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
    state_t state, state_n;

    logic [15:0]   idx;
    logic [31:0]   size, requested, loaded;
    logic [CW-1:0] outstanding, fifo_count;
    logic [AW-1:0] wptr, rptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [2:0]    hdr_cnt;
    logic [7:0]    checksum;
    logic [55:0]   hdr_vec;
    logic start_ok, xfer, out_free, req_xfer, rx_ok, rx_bad;
    logic hdr_load, pay_load, tr_load, hdr_last, pay_last, tr_done;

    assign hdr_vec   = {8'hA5, idx, size};
    assign start_ok  = readback_start && state == IDLE;
    assign xfer      = byte_for_downlink_valid && downlink_ready;
    assign out_free  = !byte_for_downlink_valid || downlink_ready;
    assign req_xfer  = flashmem_read_req && flashmem_read_ready;
    assign rx_ok     = byte_from_flashmem_spi_valid && outstanding != '0;
    assign rx_bad    = byte_from_flashmem_spi_valid && outstanding == '0;
    assign hdr_load  = state == HEADER && out_free && hdr_cnt != 3'd7;
    assign pay_load  = state == PAYLOAD && out_free && fifo_count != '0 && loaded != size;
    assign tr_load   = state == TRAILER && !byte_for_downlink_valid;
    // loaded == size while a payload byte is transferring means it is the last one
    assign hdr_last  = state == HEADER && xfer && hdr_cnt == 3'd7;
    assign pay_last  = state == PAYLOAD && xfer && loaded == size;
    assign tr_done   = state == TRAILER && xfer;
    assign readback_busy = state != IDLE;
    // credit: never request more than the FIFO can still absorb
    assign flashmem_read_req = state != IDLE && requested != size &&
        ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_n = start_ok ? HEADER :
                  hdr_last ? (size == '0 ? TRAILER : PAYLOAD) :
                  pay_last ? TRAILER :
                  tr_done  ? IDLE : state;
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) state <= IDLE;
        else           state <= state_n;
    end

    always_ff @(posedge sysClk) begin
        if (rx_ok) mem[wptr] <= byte_from_flashmem_spi;
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            idx                     <= '0;
            size                    <= '0;
            requested               <= '0;
            loaded                  <= '0;
            flashmem_read_addr      <= '0;
            outstanding             <= '0;
            fifo_count              <= '0;
            wptr                    <= '0;
            rptr                    <= '0;
            hdr_cnt                 <= '0;
            checksum                <= '0;
            byte_for_downlink       <= '0;
            byte_for_downlink_valid <= 1'b0;
            readback_done           <= 1'b0;
            readback_error          <= 1'b0;
        end else begin
            if (start_ok) begin
                idx                <= readback_image_index;
                size               <= readback_image_size;
                flashmem_read_addr <= readback_start_addr;
            end else if (req_xfer) begin
                flashmem_read_addr <= flashmem_read_addr + 1'b1;
            end
            requested   <= start_ok ? '0 : requested + 32'(req_xfer);
            loaded      <= start_ok ? '0 : loaded + 32'(pay_load);
            hdr_cnt     <= start_ok ? '0 : hdr_cnt + 3'(hdr_load);
            outstanding <= outstanding + CW'(req_xfer) - CW'(rx_ok);
            fifo_count  <= fifo_count + CW'(rx_ok) - CW'(pay_load);
            wptr        <= wptr + AW'(rx_ok);
            rptr        <= rptr + AW'(pay_load);
            checksum    <= start_ok ? '0 :
                           (state == PAYLOAD && xfer) ? checksum + byte_for_downlink : checksum;
            if (hdr_load || pay_load || tr_load) begin
                byte_for_downlink       <= hdr_load ? hdr_vec[55 - 8*int'(hdr_cnt) -: 8] :
                                           pay_load ? mem[rptr] : checksum;
                byte_for_downlink_valid <= 1'b1;
            end else if (xfer) begin
                byte_for_downlink_valid <= 1'b0;
            end
            readback_done  <= tr_done;
            readback_error <= start_ok ? rx_bad : readback_error | rx_bad;
        end
    end
endmodule

// File: tb/tb_image_readback_buffer.sv
// tb_image_readback_buffer: scoreboard bench with a latency-randomised flash model and a throttled downlink sink.
module tb_image_readback_buffer;
    logic        sysClk = 1'b0, sysRst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] index = '0;
    logic [31:0] size = '0;
    logic [23:0] saddr = '0, addr;
    logic        req, fl_ready = 1'b0, fl_valid = 1'b0;
    logic [7:0]  fl_byte = '0, dl_byte;
    logic        dl_valid, dl_ready = 1'b0, busy, done, error;

    image_readback_buffer #(.FIFO_DEPTH(16), .ADDR_W(24)) dut (
        .sysClk(sysClk), .sysRst_n(sysRst_n),
        .readback_start(start), .readback_image_index(index),
        .readback_image_size(size), .readback_start_addr(saddr),
        .flashmem_read_addr(addr), .flashmem_read_req(req), .flashmem_read_ready(fl_ready),
        .byte_from_flashmem_spi(fl_byte), .byte_from_flashmem_spi_valid(fl_valid),
        .byte_for_downlink(dl_byte), .byte_for_downlink_valid(dl_valid),
        .downlink_ready(dl_ready), .readback_busy(busy), .readback_done(done),
        .readback_error(error)
    );

    always #5 sysClk = ~sysClk;

    int checks = 0, errors = 0;
    logic [7:0]  q[$];
    logic [23:0] pend[$];
    logic [23:0] exp_addr = '0;
    logic [8:0]  e_byte;
    int acc = 0, xfers = 0, maxinf = 0, done_cnt = 0, inf;
    bit dl_hold = 0, dl_rand = 0, fl_rand = 0, inject = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return {a[3:0] + 4'd1, a[23:20]};
    endfunction

    // flash reader and downlink sink; all DUT inputs change and outputs are sampled on the falling edge
    initial forever begin
        @(negedge sysClk);
        if (!sysRst_n) begin
            pend.delete();
            fl_valid = 1'b0;
            fl_ready = 1'b0;
            dl_ready = 1'b0;
            continue;
        end
        fl_valid = 1'b0;
        if (inject) begin
            fl_valid = 1'b1;
            fl_byte  = 8'h77;
            inject   = 0;
        end else if (pend.size() != 0 && (!fl_rand || $urandom_range(0, 2) != 0)) begin
            fl_byte  = flash_byte(pend.pop_front());
            fl_valid = 1'b1;
        end
        fl_ready = !fl_rand || $urandom_range(0, 3) != 0;
        if (req && fl_ready) begin
            chk("rd_addr", 32'(addr), 32'(exp_addr));
            pend.push_back(addr);
            exp_addr++;
            acc++;
        end
        dl_ready = !dl_hold && (!dl_rand || $urandom_range(0, 1) != 0);
        if (dl_valid && dl_ready) begin
            e_byte = q.size() != 0 ? {1'b0, q.pop_front()} : 9'h100;
            chk("dl_byte", 32'(dl_byte), 32'(e_byte));
            xfers++;
        end
        if (done) done_cnt++;
        inf = acc - (xfers > 7 ? xfers - 7 : 0);
        if (inf > maxinf) maxinf = inf;
    end

    task automatic start_rb(input logic [15:0] ix, input logic [31:0] sz, input logic [23:0] ad);
        logic [7:0] cs, b;
        cs = '0;
        @(negedge sysClk);
        exp_addr = ad;
        acc = 0;
        xfers = 0;
        maxinf = 0;
        q.push_back(8'hA5);
        q.push_back(ix[15:8]);
        q.push_back(ix[7:0]);
        for (int i = 3; i >= 0; i--) q.push_back(sz[8*i +: 8]);
        for (int i = 0; i < int'(sz); i++) begin
            b = flash_byte(ad + 24'(i));
            q.push_back(b);
            cs += b;
        end
        q.push_back(cs);
        start = 1'b1;
        index = ix;
        size  = sz;
        saddr = ad;
        @(negedge sysClk);
        start = 1'b0;
        chk("busy_set", 32'(busy), 32'd1);
        chk("err_clr", 32'(error), 32'd0);
        chk("valid_lat1", 32'(dl_valid), 32'd0);
        @(negedge sysClk);
        chk("valid_lat2", 32'(dl_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int reqs);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge sysClk);
            n++;
        end
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge sysClk);
        chk({tag, "_one_pulse"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_q_left"}, 32'(q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_reqs"}, 32'(acc), 32'(reqs));
    endtask

    initial begin
        #1 chk("rst_outs", 32'({dl_valid, req, busy, done, error}), 32'd0);
        repeat (3) @(negedge sysClk);
        sysRst_n = 1'b1;
        @(negedge sysClk);
        chk("rst_release", 32'({dl_valid, req, busy, done, error}), 32'd0);

        start_rb(16'h0102, 32'd3, 24'h000010);
        wait_done("t2", 3);

        start_rb(16'h0BEE, 32'd0, 24'h000040);
        wait_done("t3", 0);

        fl_rand = 1;
        dl_hold = 1;
        start_rb(16'h0004, 32'd40, 24'h000100);
        repeat (100) @(negedge sysClk);
        chk("t4_credit", 32'(acc), 32'd16);
        dl_hold = 0;
        dl_rand = 1;
        wait_done("t4", 40);
        chk("t4_max_inflight", 32'(maxinf <= 17), 32'd1);

        start_rb(16'h0005, 32'd4, 24'hFFFFFE);
        wait_done("t5", 4);

        inject = 1;
        for (int n = 0; n < 20 && inject; n++) @(negedge sysClk);
        repeat (2) @(negedge sysClk);
        chk("t6_err_set", 32'(error), 32'd1);
        chk("t6_no_out", 32'(dl_valid), 32'd0);
        start_rb(16'h0006, 32'd5, 24'h000300);
        repeat (3) @(negedge sysClk);
        start = 1'b1;
        index = 16'hDEAD;
        size  = 32'd99;
        saddr = 24'h123456;
        @(negedge sysClk);
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'd1);
        wait_done("t6", 5);

        start_rb(16'h0007, 32'd40, 24'h000200);
        for (int n = 0; n < 2000 && xfers < 12; n++) @(negedge sysClk);
        #2 sysRst_n = 1'b0;
        #1 chk("t1_async", 32'({dl_valid, req, busy, done, error, dl_byte != 8'h0, addr != 24'h0}), 32'd0);
        q.delete();
        repeat (2) @(negedge sysClk);
        sysRst_n = 1'b1;
        @(negedge sysClk);
        chk("t1_release", 32'({dl_valid, req, busy, done, error}), 32'd0);
        fl_rand = 0;
        dl_rand = 0;
        start_rb(16'h0102, 32'd3, 24'h000010);
        wait_done("t1_after", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
